// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for the digit-serial adder/subtractor.
// The master side supplies operands and consumes results; the slave side is the arithmetic unit.
interface addsub_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             xin;
    logic             op;
    logic             clear;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] s_d;
    logic             co_bo;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, xin, op, clear, res_ready,
        input  in_ready, res_valid, s_d, co_bo, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, xin, op, clear, res_ready,
        output in_ready, res_valid, s_d, co_bo, ovf, zero
    );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: a +/- b with carry/borrow in, DIGIT bits per cycle, LSB digit first.
// Subtraction is a + ~b + ~xin; the borrow out is the inverted final carry.
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    addsub_serial_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_op;
    logic [WIDTH-1:0] r_s_d;
    logic             r_co_bo;
    logic             r_ovf;
    logic             r_zero;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic [DIGIT:0]   w_dsum;
    logic             w_msb_cin;
    logic [WIDTH-1:0] w_digit_ext;
    logic [WIDTH-1:0] w_sum_next;

    // clear overrides both the accept and the per-digit step in the same cycle
    assign w_accept = (r_state == IDLE) & bus.in_valid & ~bus.clear;
    assign w_step   = (r_state == CALC) & ~bus.clear;
    assign w_last   = (r_cnt == CW'(N - 1));

    assign w_da   = r_a[DIGIT-1:0];
    assign w_db   = r_b[DIGIT-1:0];
    assign w_dsum = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT{1'b0}}, r_carry};

    // Carry into the digit MSB recovered from the sum bit; on the last digit this is the word MSB
    assign w_msb_cin   = w_dsum[DIGIT-1] ^ w_da[DIGIT-1] ^ w_db[DIGIT-1];
    assign w_digit_ext = WIDTH'(w_dsum[DIGIT-1:0]);
    assign w_sum_next  = (r_sum >> DIGIT) | (w_digit_ext << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC;
            CALC:    if (w_last) w_next = DONE;
            DONE:    if (bus.res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (bus.clear) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_s_d   <= '0;
            r_co_bo <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_cnt <= (w_step && !w_last) ? r_cnt + 1'b1 : '0;
            if (w_step && w_last) begin
                r_s_d   <= w_sum_next;
                r_co_bo <= w_dsum[DIGIT] ^ r_op;
                r_ovf   <= w_msb_cin ^ w_dsum[DIGIT];
                r_zero  <= (w_sum_next == '0);
            end
        end
    end

    // Operand shifters and partial sum: the finished digit enters at the top, so after N steps
    // r_sum holds the whole word and no reset is needed
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.op ? ~bus.b : bus.b;
            r_carry <= bus.xin ^ bus.op;
            r_op    <= bus.op;
        end else if (w_step) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_dsum[DIGIT];
            r_sum   <= w_sum_next;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.res_valid = (r_state == DONE);
    assign bus.s_d       = r_s_d;
    assign bus.co_bo     = r_co_bo;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: directed cases on an 8/4 unit, random sweeps on 16/1 and 32/32 units,
// all checked against an arithmetic reference model.
module tb_addsub_serial;
    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] t_a;
    logic [31:0] t_b;
    logic        t_xin;
    logic        t_op;
    logic        t_valid;
    logic        t_clear;
    logic        t_res_ready;
    int          sel;
    int          checks;
    int          errors;

    logic        o_ready;
    logic        o_rv;
    logic [31:0] o_s;
    logic        o_co;
    logic        o_ovf;
    logic        o_zero;

    addsub_serial_if #(.WIDTH(8))  if8 ();
    addsub_serial_if #(.WIDTH(16)) if16 ();
    addsub_serial_if #(.WIDTH(32)) if32 ();

    addsub_serial #(.WIDTH(8),  .DIGIT(4))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    addsub_serial #(.WIDTH(16), .DIGIT(1))  u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    addsub_serial #(.WIDTH(32), .DIGIT(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

    assign if8.in_valid   = t_valid && (sel == 0);
    assign if8.a          = t_a[7:0];
    assign if8.b          = t_b[7:0];
    assign if8.xin        = t_xin;
    assign if8.op         = t_op;
    assign if8.clear      = t_clear;
    assign if8.res_ready  = t_res_ready;
    assign if16.in_valid  = t_valid && (sel == 1);
    assign if16.a         = t_a[15:0];
    assign if16.b         = t_b[15:0];
    assign if16.xin       = t_xin;
    assign if16.op        = t_op;
    assign if16.clear     = t_clear;
    assign if16.res_ready = t_res_ready;
    assign if32.in_valid  = t_valid && (sel == 2);
    assign if32.a         = t_a;
    assign if32.b         = t_b;
    assign if32.xin       = t_xin;
    assign if32.op        = t_op;
    assign if32.clear     = t_clear;
    assign if32.res_ready = t_res_ready;

    always_comb begin
        o_ready = if32.in_ready;
        o_rv    = if32.res_valid;
        o_s     = if32.s_d;
        o_co    = if32.co_bo;
        o_ovf   = if32.ovf;
        o_zero  = if32.zero;
        if (sel == 0) begin
            o_ready = if8.in_ready;
            o_rv    = if8.res_valid;
            o_s     = 32'(if8.s_d);
            o_co    = if8.co_bo;
            o_ovf   = if8.ovf;
            o_zero  = if8.zero;
        end else if (sel == 1) begin
            o_ready = if16.in_ready;
            o_rv    = if16.res_valid;
            o_s     = 32'(if16.s_d);
            o_co    = if16.co_bo;
            o_ovf   = if16.ovf;
            o_zero  = if16.zero;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cur_width();
        return (sel == 0) ? 8 : (sel == 1) ? 16 : 32;
    endfunction

    function automatic int cur_lat();
        return (sel == 0) ? 2 : (sel == 1) ? 16 : 1;
    endfunction

    // Reference: plain unsigned and signed integer arithmetic on w-bit operands
    function automatic res_t model(int w, logic [31:0] a, logic [31:0] b, logic xin, logic op);
        res_t            r;
        longint unsigned mask;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned full;
        longint          sa;
        longint          sb;
        longint          sr;
        longint          smax;
        mask = (64'd1 << w) - 64'd1;
        ua   = 64'(a) & mask;
        ub   = 64'(b) & mask;
        sa   = longint'(ua) - ((((ua >> (w - 1)) & 64'd1) != 0) ? (longint'(1) << w) : 0);
        sb   = longint'(ub) - ((((ub >> (w - 1)) & 64'd1) != 0) ? (longint'(1) << w) : 0);
        smax = (longint'(1) << (w - 1)) - 1;
        if (!op) begin
            full = ua + ub + 64'(xin);
            r.co = ((full >> w) & 64'd1) != 0;
            sr   = sa + sb + longint'(xin);
        end else begin
            full = ua - ub - 64'(xin);
            r.co = (ua < ub + 64'(xin));
            sr   = sa - sb - longint'(xin);
        end
        r.s    = 32'(full & mask);
        r.ovf  = (sr > smax) || (sr < -smax - 1);
        r.zero = (r.s == 32'd0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Accept operands, scramble the inputs during CALC, count edges until res_valid
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic xin, input logic op);
        int lat;
        @(negedge clk);
        chk("ready_before", 64'(o_ready), 64'd1);
        t_a = a; t_b = b; t_xin = xin; t_op = op; t_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_valid = 1'b0;
        t_a = $urandom; t_b = $urandom; t_xin = 1'($urandom); t_op = 1'($urandom);
        lat = 0;
        while (!o_rv && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", 64'(lat), 64'(cur_lat()));
    endtask

    task automatic check_model(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic xin, input logic op);
        res_t e;
        e = model(cur_width(), a, b, xin, op);
        chk({tag, "_s"},    64'(o_s),    64'(e.s));
        chk({tag, "_co"},   64'(o_co),   64'(e.co));
        chk({tag, "_ovf"},  64'(o_ovf),  64'(e.ovf));
        chk({tag, "_zero"}, 64'(o_zero), 64'(e.zero));
    endtask

    task automatic consume();
        t_res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_res_ready = 1'b0;
        chk("ready_after", 64'(o_ready), 64'd1);
        chk("rv_after", 64'(o_rv), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic xin, input logic op);
        start_op(a, b, xin, op);
        check_model(tag, a, b, xin, op);
        consume();
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rx;
        logic        ro;
        checks = 0; errors = 0;
        sel = 0;
        rst_n = 1'b0;
        t_a = '0; t_b = '0; t_xin = 1'b0; t_op = 1'b0;
        t_valid = 1'b0; t_clear = 1'b0; t_res_ready = 1'b0;
        #12;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_rv", 64'(o_rv), 64'd0);
        chk("rst_out", {32'd0, o_s}, 64'd0);
        chk("rst_flags", 64'({o_co, o_ovf, o_zero}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic on the 8/4 unit
        start_op(32'd100, 32'd27, 1'b0, 1'b0);
        chk("t1_s", 64'(o_s), 64'd127);
        chk("t1_flags", 64'({o_co, o_ovf, o_zero}), 64'b000);
        consume();
        start_op(32'd127, 32'd1, 1'b0, 1'b0);
        chk("t1b_s", 64'(o_s), 64'h80);
        chk("t1b_ovf", 64'(o_ovf), 64'd1);
        consume();
        start_op(32'hFF, 32'h01, 1'b0, 1'b0);
        chk("t2_s", 64'(o_s), 64'h00);
        chk("t2_flags", 64'({o_co, o_ovf, o_zero}), 64'b101);
        consume();
        start_op(32'd5, 32'd7, 1'b0, 1'b1);
        chk("t3a_s", 64'(o_s), 64'hFE);
        chk("t3a_flags", 64'({o_co, o_ovf}), 64'b10);
        consume();
        start_op(32'd10, 32'd3, 1'b1, 1'b1);
        chk("t3b_s", 64'(o_s), 64'd6);
        chk("t3b_co", 64'(o_co), 64'd0);
        consume();
        start_op(32'h80, 32'd1, 1'b0, 1'b1);
        chk("t3c_s", 64'(o_s), 64'h7F);
        chk("t3c_flags", 64'({o_co, o_ovf}), 64'b01);
        consume();

        // Backpressure with ignored in_valid pulses
        start_op(32'h3C, 32'h15, 1'b1, 1'b0);
        check_model("bp", 32'h3C, 32'h15, 1'b1, 1'b0);
        held = o_s;
        for (int i = 0; i < 5; i++) begin
            t_valid = (i % 2 == 0); t_a = 32'd1; t_b = 32'd1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_rv", 64'(o_rv), 64'd1);
            chk("bp_ready", 64'(o_ready), 64'd0);
            chk("bp_hold", 64'(o_s), 64'(held));
        end
        t_valid = 1'b0;
        consume();
        run_op("bp_next", 32'hC3, 32'h5A, 1'b0, 1'b1);

        // clear during CALC: back to IDLE, old result retained, no res_valid
        held = o_s;
        @(negedge clk);
        t_a = 32'h11; t_b = 32'h22; t_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_valid = 1'b0; t_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_clear = 1'b0;
        chk("clr_ready", 64'(o_ready), 64'd1);
        chk("clr_keep", 64'(o_s), 64'(held));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("clr_norv", 64'(o_rv), 64'd0);
        end
        run_op("after_clr", 32'h40, 32'h40, 1'b1, 1'b0);

        // Async reset in the middle of CALC
        @(negedge clk);
        t_a = 32'h99; t_b = 32'h01; t_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", 64'(o_ready), 64'd1);
        chk("mrst_rv", 64'(o_rv), 64'd0);
        chk("mrst_out", 64'({o_s, o_co, o_ovf, o_zero}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 32'h00, 32'h00, 1'b0, 1'b0);

        // Random sweeps: 16/1 then 32/32
        for (int c = 1; c <= 2; c++) begin
            sel = c;
            for (int n = 0; n < 1000; n++) begin
                ra = $urandom; rb = $urandom; rx = 1'($urandom); ro = 1'($urandom);
                if (n % 50 == 0) rb = ro ? ra : ~ra;
                run_op((c == 1) ? "r16" : "r32", ra, rb, rx, ro);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
